audio_echo_effect: RTL

//  Echo/delay effect stage between I2S receive and transmit paths of the audio effects chain.

---
 rtl/audio_echo_effect.sv | 139 +++++++++++++
 1 files changed

// File: rtl/audio_echo_effect.sv
// rtl/audio_echo_effect.sv - stereo echo/delay stage: delay line, gain multiply, saturating mix
// One pair is processed per IDLE->READ->MULT->SUM->WRITE pass; the outputs are valid while in SUM.
module audio_echo_effect #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 12,
  parameter int GAIN_WIDTH = 8,
  parameter int FEEDBACK   = 0
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic [GAIN_WIDTH-1:0] gain,
  input  logic                  bypass,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  overrun
);

  localparam int DW    = DATA_WIDTH;
  localparam int GW    = GAIN_WIDTH;
  localparam int PW    = DW + GW + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic signed [PW-1:0] SAT_HI = {{(GW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(GW + 2){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {IDLE, READ, MULT, SUM, WRITE} state_t;

  state_t                state, state_next;
  logic                  capture;
  logic [DW-1:0]         in_l_q, in_r_q;
  logic [ADDR_WIDTH-1:0] dly_q;
  logic [GW-1:0]         gain_q;
  logic                  byp_q;
  logic [ADDR_WIDTH-1:0] wr_ptr, fill_cnt, rd_addr;
  logic [DW-1:0]         mem_l [DEPTH];
  logic [DW-1:0]         mem_r [DEPTH];
  logic [DW-1:0]         rd_l, rd_r;
  logic                  echo_en;
  logic [DW-1:0]         dly_l, dly_r, mix_l, mix_r, wr_l, wr_r;

  // Product is sized so no bits are lost; the sum is taken at the same width and then clamped.
  function automatic logic [DW-1:0] echo_mix(input logic [DW-1:0] dry,
                                             input logic [DW-1:0] dly,
                                             input logic [GW-1:0] g);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sum;
    prod = $signed({{(GW + 1){dly[DW-1]}}, dly}) * $signed({{(DW + 1){1'b0}}, g});
    sum  = $signed({{(GW + 1){dry[DW-1]}}, dry}) + (prod >>> GW);
    if (sum > SAT_HI)      echo_mix = {1'b0, {(DW - 1){1'b1}}};
    else if (sum < SAT_LO) echo_mix = {1'b1, {(DW - 1){1'b0}}};
    else                   echo_mix = sum[DW-1:0];
  endfunction

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    out_valid  = 1'b0;
    overrun    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture    = 1'b1;
          state_next = READ;
        end
      end
      READ:  state_next = MULT;
      MULT:  state_next = SUM;
      SUM: begin
        out_valid  = 1'b1;
        state_next = WRITE;
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (in_valid && state != IDLE) overrun = 1'b1;
  end

  assign rd_addr = wr_ptr - dly_q;
  // fill_cnt hides RAM words never written since reset.
  assign echo_en = (dly_q != '0) && (fill_cnt >= dly_q);
  assign dly_l   = echo_en ? rd_l : '0;
  assign dly_r   = echo_en ? rd_r : '0;
  assign mix_l   = echo_mix(in_l_q, dly_l, gain_q);
  assign mix_r   = echo_mix(in_r_q, dly_r, gain_q);
  assign wr_l    = (FEEDBACK != 0) ? out_left  : in_l_q;
  assign wr_r    = (FEEDBACK != 0) ? out_right : in_r_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      in_l_q    <= '0;
      in_r_q    <= '0;
      dly_q     <= '0;
      gain_q    <= '0;
      byp_q     <= 1'b0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      out_left  <= '0;
      out_right <= '0;
    end else begin
      if (capture) begin
        in_l_q <= in_left;
        in_r_q <= in_right;
        dly_q  <= delay_len;
        gain_q <= gain;
        byp_q  <= bypass;
      end
      if (state == MULT) begin
        out_left  <= byp_q ? in_l_q : mix_l;
        out_right <= byp_q ? in_r_q : mix_r;
      end
      if (state == WRITE) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (state == READ) begin
      rd_l <= mem_l[rd_addr];
      rd_r <= mem_r[rd_addr];
    end
    if (state == WRITE) begin
      mem_l[wr_ptr] <= wr_l;
      mem_r[wr_ptr] <= wr_r;
    end
  end

endmodule
